// File: rtl/note_sequencer.sv
// note_sequencer
//   Walks a song stored in an external word memory. Each word carries a length code in
//   bits [7:5] (note lasts L+1 beats) and a note index in bits [4:0] (0 = rest). For every
//   word the sequencer issues a one-cycle fetch, waits a bounded time for the memory to
//   answer, sounds the note for its length, then inserts a short silent articulation gap.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   i_start           level: begin playback when idle
//   i_pause           level: freeze note/gap timing while high
//   i_stop            level: abort playback (wins over i_start)
//   o_read_en         one-cycle fetch request to the memory unit
//   o_read_rst        one-cycle rewind of the memory read pointer
//   i_data_in         memory word, qualified by i_output_ready
//   i_output_ready    memory word is valid (only honoured while waiting for a word)
//   i_duration        number of words in the song
//   o_note_out        latched note index for the tone generator
//   o_note_valid      tone is sounding
//   o_index           words consumed so far (saturating)
//   o_busy            sequencer is not idle
//   o_done            one-cycle pulse at song end or on memory timeout
//   o_error           sticky memory-timeout flag, cleared by the next real start
module note_sequencer #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned MAX_DEPTH_BIT = 8,
   parameter int unsigned BEAT_TICKS    = 25_000_000,
   parameter int unsigned GAP_TICKS     = 2_500_000,
   parameter int unsigned WAIT_LIMIT    = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_start,
   input  logic                     i_pause,
   input  logic                     i_stop,
   output logic                     o_read_en,
   output logic                     o_read_rst,
   input  logic [DATA_WIDTH-1:0]    i_data_in,
   input  logic                     i_output_ready,
   input  logic [MAX_DEPTH_BIT-1:0] i_duration,
   output logic [4:0]               o_note_out,
   output logic                     o_note_valid,
   output logic [MAX_DEPTH_BIT-1:0] o_index,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_error
);

   // Longest note is 8 beats; the counter also has to hold the gap length.
   localparam int unsigned PlayMax = 8 * BEAT_TICKS;
   localparam int unsigned CntMax  = (PlayMax > GAP_TICKS) ? PlayMax : GAP_TICKS;
   localparam int unsigned CntW    = $clog2(CntMax + 1);
   localparam int unsigned WaitW   = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

   localparam logic [CntW-1:0]  BeatCnt  = CntW'(BEAT_TICKS);
   localparam logic [CntW-1:0]  GapCnt   = CntW'(GAP_TICKS);
   localparam logic [CntW-1:0]  CntOne   = CntW'(1);
   localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_LIMIT - 1);
   localparam logic [WaitW-1:0] WaitOne  = WaitW'(1);
   localparam logic [MAX_DEPTH_BIT-1:0] IdxOne = MAX_DEPTH_BIT'(1);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StWait,
      StPlay,
      StGap,
      StDone
   } state_e;

   state_e                   r_state;
   logic [CntW-1:0]          r_cnt;
   logic [WaitW-1:0]         r_wait_cnt;
   logic [4:0]               r_note;
   logic [MAX_DEPTH_BIT-1:0] r_index;
   logic                     r_error;
   logic                     r_read_rst;

   state_e                   w_state_next;
   logic [CntW-1:0]          w_cnt_next;
   logic [WaitW-1:0]         w_wait_cnt_next;
   logic [4:0]               w_note_next;
   logic [MAX_DEPTH_BIT-1:0] w_index_next;
   logic                     w_error_next;
   logic                     w_read_rst_next;

   logic [2:0]               w_len;
   logic [CntW-1:0]          w_play_load;

   assign w_len       = i_data_in[7:5];
   assign w_play_load = (CntW'(w_len) + CntOne) * BeatCnt;

   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = r_cnt;
      w_wait_cnt_next = r_wait_cnt;
      w_note_next     = r_note;
      w_index_next    = r_index;
      w_error_next    = r_error;
      w_read_rst_next = 1'b0;

      if (i_stop) begin
         w_state_next    = StIdle;
         w_read_rst_next = 1'b1;
         w_cnt_next      = '0;
         w_wait_cnt_next = '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  if (i_duration != '0) begin
                     w_state_next    = StFetch;
                     w_read_rst_next = 1'b1;
                     w_index_next    = '0;
                     w_error_next    = 1'b0;
                  end else begin
                     w_state_next = StDone;
                  end
               end
            end
            StFetch: begin
               w_state_next    = StWait;
               w_wait_cnt_next = '0;
            end
            StWait: begin
               if (i_output_ready) begin
                  w_note_next  = i_data_in[4:0];
                  w_index_next = (r_index == '1) ? r_index : r_index + IdxOne;
                  w_cnt_next   = w_play_load;
                  w_state_next = StPlay;
               end else if (r_wait_cnt == WaitLast) begin
                  w_error_next = 1'b1;
                  w_state_next = StDone;
               end else begin
                  w_wait_cnt_next = r_wait_cnt + WaitOne;
               end
            end
            StPlay: begin
               if (!i_pause) begin
                  // Leave on the cycle the count would reach zero, so PLAY lasts exactly
                  // the loaded number of unpaused cycles.
                  if (r_cnt <= CntOne) begin
                     w_cnt_next   = GapCnt;
                     w_state_next = StGap;
                  end else begin
                     w_cnt_next = r_cnt - CntOne;
                  end
               end
            end
            StGap: begin
               if (!i_pause) begin
                  if (r_cnt <= CntOne) begin
                     w_cnt_next   = '0;
                     w_state_next = (r_index < i_duration) ? StFetch : StDone;
                  end else begin
                     w_cnt_next = r_cnt - CntOne;
                  end
               end
            end
            StDone: begin
               w_state_next = StIdle;
            end
            default: begin
               w_state_next = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_wait_cnt <= '0;
         r_note     <= '0;
         r_index    <= '0;
         r_error    <= 1'b0;
         r_read_rst <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_wait_cnt <= w_wait_cnt_next;
         r_note     <= w_note_next;
         r_index    <= w_index_next;
         r_error    <= w_error_next;
         r_read_rst <= w_read_rst_next;
      end
   end

   assign o_read_en    = (r_state == StFetch);
   assign o_read_rst   = r_read_rst;
   assign o_note_out   = r_note;
   assign o_note_valid = (r_state == StPlay) && (r_note != 5'd0) && !i_pause;
   assign o_index      = r_index;
   assign o_busy       = (r_state != StIdle);
   assign o_done       = (r_state == StDone);
   assign o_error      = r_error;

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Parameters
REQ-001 SHALL provide DATA_WIDTH, default 8, meaning memory word width: bits [7:5] length code L, bits [4:0] note index (0 = rest).
REQ-002 SHALL provide MAX_DEPTH_BIT, default 8, meaning width of the song-length and word-index fields.
REQ-003 SHALL provide BEAT_TICKS, default 25_000_000, meaning clk cycles per beat.
REQ-004 SHALL provide GAP_TICKS, default 2_500_000, meaning silent articulation cycles after each note.
REQ-005 SHALL provide WAIT_LIMIT, default 16, meaning the maximum number of cycles to wait for output_ready.

Interface
REQ-006 SHALL have clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have start, input, 1 bit: level, begin playback when idle.
REQ-009 SHALL have pause, input, 1 bit: level, freeze timing while high.
REQ-010 SHALL have stop, input, 1 bit: level, abort playback.
REQ-011 SHALL have read_en, output, 1 bit: one-cycle fetch request to the memory unit.
REQ-012 SHALL have read_rst, output, 1 bit: one-cycle rewind of the memory read pointer.
REQ-013 SHALL have data_in, input, DATA_WIDTH bits: memory word.
REQ-014 SHALL have output_ready, input, 1 bit: data_in is valid.
REQ-015 SHALL have duration, input, MAX_DEPTH_BIT bits: number of words in the song.
REQ-016 SHALL have note_out, output, 5 bits: current note index to the tone generator.
REQ-017 SHALL have note_valid, output, 1 bit: high while the tone is sounding.
REQ-018 SHALL have index, output, MAX_DEPTH_BIT bits: count of words consumed.
REQ-019 SHALL have busy, output, 1 bit: high in any state other than IDLE.
REQ-020 SHALL have done, output, 1 bit: one-cycle pulse at song end or on timeout.
REQ-021 SHALL have error, output, 1 bit: sticky flag for output_ready timeout.

Function
REQ-022 SHALL implement the states IDLE, FETCH, WAIT, PLAY, GAP and DONE.
REQ-023 SHALL, in IDLE with start=1 and duration!=0, pulse read_rst for 1 cycle, clear index and error, and go to FETCH.
REQ-024 SHALL, in IDLE with start=1 and duration==0, go to DONE with no read_en issued.
REQ-025 SHALL, in FETCH, assert read_en for exactly 1 cycle and then go to WAIT.
REQ-026 SHALL, in WAIT, latch data_in on the first cycle output_ready=1, increment index, load the beat counter with (L+1)*BEAT_TICKS, and go to PLAY.
REQ-027 SHALL, in WAIT, go to DONE and set error=1 if output_ready has not been seen after WAIT_LIMIT cycles.
REQ-028 SHALL, in PLAY, drive note_out from the latched word; note_valid SHALL be 1 when the note is nonzero and pause=0, else 0.
REQ-029 SHALL, in PLAY, decrement the counter each cycle pause=0; on reaching 0 it SHALL go to GAP with the counter loaded with GAP_TICKS.
REQ-030 SHALL, in GAP, hold note_valid=0; on counter expiry it SHALL go to FETCH if index<duration, else go to DONE.
REQ-031 SHALL, in DONE, pulse done for 1 cycle and return to IDLE; note_out, index and error SHALL hold their values.
REQ-032 SHALL freeze all counters in PLAY and GAP while pause=1; pause SHALL have no effect in IDLE, FETCH or WAIT.
REQ-033 SHALL, on stop=1 in any state, go to IDLE on the next edge with note_valid=0 and read_rst pulsed, and SHALL NOT pulse done.
REQ-034 SHALL give stop priority over start when both are asserted; start while busy SHALL be ignored.
REQ-035 SHALL ignore output_ready outside WAIT.
REQ-036 SHALL saturate index at all-ones rather than wrap to 0.
REQ-037 SHALL size the counters to hold 8*BEAT_TICKS without overflow.

Reset
REQ-038 SHALL, with rst_n=0, asynchronously force state=IDLE; read_en, read_rst, note_valid, busy, done and error =0; note_out=0; index=0; counters=0.
REQ-039 SHALL, when rst_n is asserted mid-playback, drop note_valid immediately with no done pulse.

Verification (BEAT_TICKS=4, GAP_TICKS=1, WAIT_LIMIT=16)
REQ-040 SHALL verify: duration=2, words 8'h23 and 8'h05, ready 1 cycle after read_en -> note 3 valid 8 cycles, 1 gap cycle, note 5 valid 4 cycles, done pulse, index=2.
REQ-041 SHALL verify: word 8'h40 (rest, L=2) -> note_valid stays 0 for 12 cycles, then GAP is entered.
REQ-042 SHALL verify: pause held 5 cycles mid-PLAY -> the note lasts 5 cycles longer, and note_valid=0 during the pause.
REQ-043 SHALL verify: output_ready never asserted -> done pulse and error=1 on the 17th WAIT cycle.
REQ-044 SHALL verify: start and stop asserted together in PLAY -> IDLE next cycle, read_rst pulsed, no done pulse; duration=0 with start -> done pulse and no read_en.
REQ-045 SHALL verify: rst_n low mid-PLAY -> all outputs return to 0 asynchronously.
